gate_sweep_checker: RTL and testbench
=====================================

Name: gate_sweep_checker

Overview:
- Self-checking stimulus/response stage wrapped around the two-input combinational gate bank.
- Drives operand pair a/b through all four input combinations.
- Samples the bank's seven gate outputs after a programmable settle window and compares them against internally computed expected values.
- Reports pass/fail, a sticky per-gate error mask and a failing-vector count. Sits directly upstream of the gate bank (feeds a, b) and consumes its outputs.

Parameters:
- SETTLE_CYCLES, 1, extra cycles each vector is held before sampling; legal range 0..255.
- NUM_PASSES, 1, number of full 4-vector sweeps per start; legal range 1..15.
- CNT_W, 4, width of err_count.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin sweep; sampled only in IDLE
- a_out  output  1  operand a to gate bank
- b_out  output  1  operand b to gate bank
- gate_in  input  7  bank outputs: [0]=and, [1]=or, [2]=not(a), [3]=nand, [4]=nor, [5]=xor, [6]=xnor
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse at sweep end
- pass  output  1  1 = last sweep had zero mismatches; held until next start
- err_mask  output  7  sticky per-gate mismatch flags, same bit order as gate_in
- err_count  output  CNT_W  number of vectors with at least one mismatching bit; saturating

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - a_out=b_out=busy=done=pass=0.
  - err_mask=0, err_count=0.
  - Reset mid-sweep aborts immediately; no done pulse.
- State machine: IDLE -> HOLD -> (compare) -> HOLD ... -> FINISH -> IDLE.
- IDLE:
  - a_out=b_out=0, busy=0.
  - On a clock edge with start=1 (edge E0):
    - vec=2'b00, pass_idx=0, hold counter=SETTLE_CYCLES.
    - err_mask<=0, err_count<=0, pass<=0, busy<=1.
    - Go to HOLD.
- HOLD:
  - {a_out,b_out}=vec, registered.
  - Each edge decrements the hold counter while it is nonzero.
  - On the edge where the counter is 0 (compare edge), gate_in is compared against expected = {~(a^b), a^b, ~(a|b), ~(a&b), ~a, a|b, a&b} for the current vec.
- Compare timing:
  - Compare edges occur at E0 + k*(SETTLE_CYCLES+1), k = 1..4*NUM_PASSES.
  - Each vector is held for exactly SETTLE_CYCLES+1 cycles.
  - SETTLE_CYCLES=0 means a one-cycle hold, sampled at the end of that cycle.
- At each compare edge:
  - err_mask |= (gate_in ^ expected).
  - If any bit mismatches, err_count += 1, saturating at 2^CNT_W-1.
  - vec increments 00->01->10->11 (a=vec[1], b=vec[0]); hold counter reloads.
  - At vec=11 wrap: vec goes to 00 and pass_idx increments.
  - After the final vector of the final pass, go to FINISH instead.
- FINISH (registered update on the final compare edge, visible the following cycle):
  - done=1 for exactly one cycle.
  - busy=0, a_out=b_out=0.
  - pass = (err_count==0 including the final compare).
  - Return to IDLE next edge.
- start while busy or in FINISH: ignored, no restart.
- start held high continuously: a new sweep begins on the first IDLE edge after FINISH.
- err_mask, err_count and pass are held stable from FINISH until the next accepted start.
- gate_in is ignored on non-compare edges.

Test Plan:
- SETTLE_CYCLES=1, NUM_PASSES=1, correct gate bank, start pulsed at E0 -> compares at E0+2/4/6/8; done high the cycle after E0+8; pass=1, err_mask=0, err_count=0.
- Bank with nor output replaced by a^b -> mismatches at vectors 00, 01, 10 (not 11); err_mask=7'b0010000, err_count=3, pass=0.
- CNT_W=2, NUM_PASSES=2, all gate_in bits inverted -> 8 failing vectors; err_count saturates at 3, err_mask=7'h7F, pass=0.
- SETTLE_CYCLES=0, correct bank -> a_out/b_out change every cycle (00,01,10,11); done the cycle after E0+4; start re-pulsed while busy has no effect on the sequence.
- rst_n asserted during vector 10 -> all outputs 0 immediately; no done pulse; a subsequent start runs a full clean sweep with pass=1.
- Start held high for 20 cycles, SETTLE_CYCLES=1 -> back-to-back sweeps with done pulses 10 cycles apart; err outputs clear at each new start.

Source files
------------

// File: rtl/gate_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate_sweep_checker
// Purpose  : Stimulus/response checker for a two-input combinational gate
//            bank. Walks {a,b} through 00,01,10,11 for NUM_PASSES sweeps.
//            Each vector is held SETTLE_CYCLES+1 cycles. The bank outputs
//            are then compared against the expected gate truth values.
// Ports    : clk        rising-edge clock
//            rst_n      asynchronous active-low reset
//            start      begin a sweep (sampled only while idle)
//            a_out      operand a to the gate bank
//            b_out      operand b to the gate bank
//            gate_in    bank outputs {xnor,xor,nor,nand,not a,or,and}
//            busy       sweep in progress
//            done       one-cycle pulse when a sweep completes
//            pass       last sweep saw no mismatches
//            err_mask   sticky per-gate mismatch flags (gate_in order)
//            err_count  saturating count of failing vectors
// Revision : 1.0 - initial release
// ============================================================================
module gate_sweep_checker #(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_PASSES    = 1,
    parameter int CNT_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic [6:0]       gate_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [6:0]       err_mask,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [7:0]       c_settle    = 8'(SETTLE_CYCLES);
    localparam logic [3:0]       c_last_pass = 4'(NUM_PASSES - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = '1;

    state_t           r_state,     w_state_nxt;
    logic [1:0]       r_vec,       w_vec_nxt;
    logic [3:0]       r_pass_idx,  w_pass_idx_nxt;
    logic [7:0]       r_hold,      w_hold_nxt;
    logic             r_a,         w_a_nxt;
    logic             r_b,         w_b_nxt;
    logic             r_busy,      w_busy_nxt;
    logic             r_done,      w_done_nxt;
    logic             r_pass,      w_pass_nxt;
    logic [6:0]       r_err_mask,  w_err_mask_nxt;
    logic [CNT_W-1:0] r_err_count, w_err_count_nxt;

    logic             w_vec_a;
    logic             w_vec_b;
    logic [6:0]       w_expected;
    logic [6:0]       w_miss;
    logic [CNT_W-1:0] w_cnt_upd;
    logic [1:0]       w_vec_inc;
    logic             w_last_vec;

    // The vector register is the operand pair currently applied to the bank.
    assign w_vec_a    = r_vec[1];
    assign w_vec_b    = r_vec[0];
    assign w_expected = {~(w_vec_a ^ w_vec_b), w_vec_a ^ w_vec_b,
                         ~(w_vec_a | w_vec_b), ~(w_vec_a & w_vec_b),
                         ~w_vec_a, w_vec_a | w_vec_b, w_vec_a & w_vec_b};
    assign w_miss     = gate_in ^ w_expected;
    assign w_cnt_upd  = ((|w_miss) && (r_err_count != c_cnt_max)) ?
                        r_err_count + CNT_W'(1) : r_err_count;
    assign w_vec_inc  = r_vec + 2'd1;
    assign w_last_vec = (r_vec == 2'b11) && (r_pass_idx == c_last_pass);

    always_comb begin
        w_state_nxt     = r_state;
        w_vec_nxt       = r_vec;
        w_pass_idx_nxt  = r_pass_idx;
        w_hold_nxt      = r_hold;
        w_a_nxt         = r_a;
        w_b_nxt         = r_b;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_pass_nxt      = r_pass;
        w_err_mask_nxt  = r_err_mask;
        w_err_count_nxt = r_err_count;

        case (r_state)
            ST_IDLE: begin
                w_a_nxt    = 1'b0;
                w_b_nxt    = 1'b0;
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_state_nxt     = ST_HOLD;
                    w_vec_nxt       = 2'b00;
                    w_pass_idx_nxt  = 4'd0;
                    w_hold_nxt      = c_settle;
                    w_err_mask_nxt  = 7'd0;
                    w_err_count_nxt = '0;
                    w_pass_nxt      = 1'b0;
                    w_busy_nxt      = 1'b1;
                end
            end
            ST_HOLD: begin
                if (r_hold != 8'd0) begin
                    w_hold_nxt = r_hold - 8'd1;
                end else begin
                    // Compare edge: fold this vector's result into the
                    // sticky status, then advance or wrap up.
                    w_err_mask_nxt  = r_err_mask | w_miss;
                    w_err_count_nxt = w_cnt_upd;
                    if (w_last_vec) begin
                        w_state_nxt = ST_FINISH;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_a_nxt     = 1'b0;
                        w_b_nxt     = 1'b0;
                        w_pass_nxt  = (w_cnt_upd == '0);
                    end else begin
                        w_vec_nxt  = w_vec_inc;
                        w_hold_nxt = c_settle;
                        w_a_nxt    = w_vec_inc[1];
                        w_b_nxt    = w_vec_inc[0];
                        if (r_vec == 2'b11) begin
                            w_pass_idx_nxt = r_pass_idx + 4'd1;
                        end
                    end
                end
            end
            ST_FINISH: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_vec       <= 2'b00;
            r_pass_idx  <= 4'd0;
            r_hold      <= 8'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_mask  <= 7'd0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_vec       <= w_vec_nxt;
            r_pass_idx  <= w_pass_idx_nxt;
            r_hold      <= w_hold_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_err_mask  <= w_err_mask_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_mask  = r_err_mask;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_sweep_checker
// Purpose  : Scoreboard bench for gate_sweep_checker. Two instances are used:
//            one with a settle window, one with zero settle, two passes and a
//            2-bit counter. Each instance has a modelled gate bank with
//            per-vector fault injection and noise on non-sampling edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_checker;

    localparam int S0 = 1, P0 = 1, W0 = 4;
    localparam int S1 = 0, P1 = 2, W1 = 2;

    typedef struct {
        int         inst;
        int         e0;
        logic [6:0] mask;
        int         count;
        bit         pass;
    } exp_t;

    exp_t sbq[$];

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    start = 2'b00;
    logic [1:0]    a_o, b_o, busy, done, pass;
    logic [6:0]    gate_in  [2];
    logic [6:0]    err_mask [2];
    logic [3:0]    err_cnt  [2];
    logic [W0-1:0] cnt0;
    logic [W1-1:0] cnt1;
    logic [6:0]    corr [2][4];
    int            cyc      = 0;
    int            n_checks = 0;
    int            n_pass   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gate_sweep_checker #(.SETTLE_CYCLES(S0), .NUM_PASSES(P0), .CNT_W(W0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .a_out(a_o[0]), .b_out(b_o[0]),
        .gate_in(gate_in[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_mask(err_mask[0]), .err_count(cnt0));

    gate_sweep_checker #(.SETTLE_CYCLES(S1), .NUM_PASSES(P1), .CNT_W(W1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .a_out(a_o[1]), .b_out(b_o[1]),
        .gate_in(gate_in[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_mask(err_mask[1]), .err_count(cnt1));

    assign err_cnt[0] = 4'(cnt0);
    assign err_cnt[1] = 4'(cnt1);

    function automatic int settle_of(input int i);
        return (i == 0) ? S0 : S1;
    endfunction
    function automatic int passes_of(input int i);
        return (i == 0) ? P0 : P1;
    endfunction
    function automatic int cmax_of(input int i);
        return (i == 0) ? ((1 << W0) - 1) : ((1 << W1) - 1);
    endfunction

    // Correct two-input gate bank behaviour.
    function automatic logic [6:0] ideal(input logic a, input logic b);
        logic [6:0] g;
        g[0] = a & b;
        g[1] = a | b;
        g[2] = ~a;
        g[3] = ~(a & b);
        g[4] = ~(a | b);
        g[5] = a ^ b;
        g[6] = ~(a ^ b);
        return g;
    endfunction

    task automatic check(input string name, input int inst,
                         input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s[%0d] cyc=%0d: got 0x%0h expected 0x%0h",
                      name, inst, cyc, got, exp);
    endtask

    // Reference result of one sweep: every pass sees the same faulty table.
    task automatic push(input int i, input int e0);
        exp_t t;
        t.inst  = i;
        t.e0    = e0;
        t.mask  = 7'd0;
        t.count = 0;
        for (int p = 0; p < passes_of(i); p++) begin
            for (int v = 0; v < 4; v++) begin
                t.mask |= corr[i][v];
                if (corr[i][v] != 7'd0 && t.count < cmax_of(i)) t.count++;
            end
        end
        t.pass = (t.count == 0);
        sbq.push_back(t);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (sbq.size() > 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        if (sbq.size() > 0) begin
            n_checks++;
            $display("FAIL timeout: %0d sweep(s) never completed", sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Hold start for 'hold' cycles; every accepted start is predicted from
    // the sweep length plus the FINISH and IDLE cycles that follow it.
    task automatic run(input int i, input int hold, input bit poke);
        int e, len;
        len = 4 * passes_of(i) * (settle_of(i) + 1);
        e   = cyc + 1;
        while (e <= cyc + hold) begin
            push(i, e);
            e += len + 2;
        end
        start[i] = 1'b1;
        repeat (hold) @(negedge clk);
        start[i] = 1'b0;
        if (poke) begin
            repeat (2) @(negedge clk);
            start[i] = 1'b1;
            @(negedge clk);
            start[i] = 1'b0;
        end
        wait_idle();
    endtask

    task automatic set_clean(input int i);
        for (int v = 0; v < 4; v++) corr[i][v] = 7'd0;
    endtask

    task automatic set_random(input int i);
        for (int v = 0; v < 4; v++)
            corr[i][v] = ($urandom_range(0, 1) != 0) ? 7'($urandom) : 7'd0;
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_mon
        localparam int SS = (gi == 0) ? S0 : S1;
        localparam int LL = 4 * ((gi == 0) ? P0 : P1) * (SS + 1);
        logic [6:0] noise = 7'd0;

        assign gate_in[gi] = ideal(a_o[gi], b_o[gi]) ^ corr[gi][{a_o[gi], b_o[gi]}] ^ noise;

        always @(negedge clk) begin
            bit         act;
            int         e0, n;
            logic       exp_busy, exp_done;
            logic [1:0] exp_ab;
            act = (sbq.size() > 0) && (sbq[0].inst == gi);
            e0  = act ? sbq[0].e0 : 0;
            n   = cyc + 1;
            // Garbage on every edge that is not a sampling edge.
            noise = (act && n > e0 && n <= e0 + LL && ((n - e0) % (SS + 1)) == 0) ?
                    7'd0 : 7'($urandom);
            if (rst_n) begin
                exp_busy = act && cyc >= e0 && cyc < e0 + LL;
                exp_done = act && cyc == e0 + LL;
                exp_ab   = exp_busy ? 2'(((cyc - e0) / (SS + 1)) % 4) : 2'b00;
                check("ctl{busy,done,a,b}", gi,
                      32'({busy[gi], done[gi], a_o[gi], b_o[gi]}),
                      32'({exp_busy, exp_done, exp_ab}));
                if (act && cyc == e0)
                    check("clear_on_start", gi,
                          32'({err_mask[gi], err_cnt[gi], pass[gi]}), 32'd0);
                if (exp_done) begin
                    check("err_mask", gi, 32'(err_mask[gi]), 32'(sbq[0].mask));
                    check("err_count", gi, 32'(err_cnt[gi]), 32'(sbq[0].count));
                    check("pass", gi, 32'(pass[gi]), 32'(sbq[0].pass));
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] vv;
        int         e0;
        for (int i = 0; i < 2; i++) set_clean(i);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++)
            check("reset_state", i, 32'({a_o[i], b_o[i], busy[i], done[i], pass[i],
                  err_mask[i], err_cnt[i]}), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Instance 0: settle window of one cycle, single pass.
        run(0, 1, 1'b0);
        for (int v = 0; v < 4; v++) begin
            vv = 2'(v);
            corr[0][v] = {2'b00, (~(vv[1] | vv[0])) ^ (vv[1] ^ vv[0]), 4'b0000};
        end
        run(0, 1, 1'b0);
        set_clean(0);
        run(0, 20, 1'b0);
        for (int r = 0; r < 4; r++) begin
            set_random(0);
            run(0, 1, r[0]);
        end

        // Abort while vector 10 is applied.
        set_clean(0);
        e0 = cyc + 1;
        push(0, e0);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        while (cyc < e0 + 2 * (S0 + 1)) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", 0, 32'({a_o[0], b_o[0], busy[0], done[0], pass[0],
              err_mask[0], err_cnt[0]}), 32'd0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run(0, 1, 1'b0);

        // Instance 1: zero settle, two passes, 2-bit saturating counter.
        for (int v = 0; v < 4; v++) corr[1][v] = 7'h7F;
        run(1, 1, 1'b0);
        set_clean(1);
        run(1, 1, 1'b1);
        for (int r = 0; r < 4; r++) begin
            set_random(1);
            run(1, 1 + 10 * r[0], r[1]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
